delay_scheduler: RTL and testbench

- Shares one millisecond delay timer among NREQ requesters, e.g. LCD controller init/command waits and the clock-tick generator.
- Each requester posts a delay request. The block picks one winner at a time by round-robin, times that winner's delay with an internal MFREQ_KHZ prescaler and ms counter, then returns a one-cycle done pulse to that requester.
- Sits between the LCD/clock front-ends and the system clock domain. It replaces one private timer per client.

---
 rtl/delay_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_delay_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_scheduler.sv
// delay_scheduler: one shared millisecond delay timer for NREQ requesters.
// Requests are granted one at a time by round-robin. The winner's delay is
// timed with an MFREQ_KHZ-cycle prescaler and a millisecond counter, and the
// block then returns a one-cycle done pulse to that requester.
// Optional feature: define DELAY_SCHED_CANCEL_EN to add a per-requester
// cancel input. The owner can use it to abort its running delay.
module delay_scheduler #(
    parameter int NREQ      = 4,
    parameter int MFREQ_KHZ = 1
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   delay_ms,
`ifdef DELAY_SCHED_CANCEL_EN
    input  logic [NREQ-1:0]      cancel,
`endif
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [2:0]           owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Last prescaler value before it wraps and emits a millisecond tick.
    localparam logic [31:0] PRESC_MAX = 32'(MFREQ_KHZ - 1);

    state_t        state;
    state_t        state_next;

    logic [2:0]    ptr;
    logic [15:0]   d_reg;
    logic [31:0]   presc;
    logic [16:0]   ms_cnt;

    logic          hi_hit;
    logic          lo_hit;
    logic [2:0]    hi_idx;
    logic [2:0]    lo_idx;
    logic          any_req;
    logic [2:0]    winner;

    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] own_onehot;
    logic [15:0]     win_delay;
    logic            own_cancel;

    logic          tick;
    logic          expired;
    logic          do_grant;
    logic          do_finish;
    logic          do_abort;

    // Round-robin winner: lowest requester at or above the pointer, else lowest below it.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = 3'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = 3'(i);
                end
            end
        end
        any_req = hi_hit | lo_hit;
        winner  = hi_hit ? hi_idx : lo_idx;
    end

    // One-hot decode of winner and owner, and selection of the winner's delay slice.
    always_comb begin
        win_onehot = '0;
        own_onehot = '0;
        win_delay  = 16'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == winner) begin
                win_onehot[i] = 1'b1;
                win_delay     = delay_ms[16*i +: 16];
            end
            if (3'(i) == owner) begin
                own_onehot[i] = 1'b1;
            end
        end
    end

`ifdef DELAY_SCHED_CANCEL_EN
    // Only the current owner's cancel bit is honoured.
    assign own_cancel = |(cancel & own_onehot);
`else
    assign own_cancel = 1'b0;
`endif

    assign tick    = (presc == PRESC_MAX);
    assign expired = (ms_cnt == {1'b0, d_reg});

    // State register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant in IDLE; abort or finish in COUNT (abort wins).
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_finish  = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    do_grant   = 1'b1;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (own_cancel) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else if (expired) begin
                    do_finish  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and registered handshake outputs; ack and done are single-cycle pulses.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            ack   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            owner <= 3'd0;
            ptr   <= 3'd0;
            d_reg <= 16'd0;
        end else begin
            ack  <= '0;
            done <= '0;
            if (do_grant) begin
                ack   <= win_onehot;
                owner <= winner;
                d_reg <= win_delay;
                busy  <= 1'b1;
                ptr   <= (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
            end else if (do_finish) begin
                done <= own_onehot;
                busy <= 1'b0;
            end else if (do_abort) begin
                busy <= 1'b0;
            end
        end
    end

    // Prescaler and millisecond counter. Both clear at grant; ms advances on each prescaler wrap.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            presc  <= 32'd0;
            ms_cnt <= 17'd0;
        end else if (do_grant) begin
            presc  <= 32'd0;
            ms_cnt <= 17'd0;
        end else if (state == COUNT) begin
            if (tick) begin
                presc  <= 32'd0;
                ms_cnt <= ms_cnt + 17'd1;
            end else begin
                presc <= presc + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// tb_delay_scheduler: scoreboard bench for delay_scheduler.
// The main instance uses NREQ=4, MFREQ_KHZ=2. A second instance with
// NREQ=2, MFREQ_KHZ=1 times the 0xFFFF boundary delay in parallel.
module tb_delay_scheduler;

    localparam int N = 4;
    localparam int M = 2;

    logic            mclk = 1'b0;
    logic            rst  = 1'b1;
    logic [N-1:0]    req  = '0;
    logic [16*N-1:0] delay_ms = '0;
`ifdef DELAY_SCHED_CANCEL_EN
    logic [N-1:0]    cancel = '0;
    logic [1:0]      cancel2 = '0;
`endif
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic            busy;
    logic [2:0]      owner;

    logic            rst2 = 1'b1;
    logic [1:0]      req2 = '0;
    logic [31:0]     delay2 = '0;
    logic [1:0]      ack2;
    logic [1:0]      done2;
    logic            busy2;
    logic [2:0]      owner2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit is_done;
        int idx;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    int m_ptr   = 0;
    int m_ack   = 0;
    int m_free  = 0;
    int m_owner = 0;

    delay_scheduler #(.NREQ(N), .MFREQ_KHZ(M)) dut (
        .mclk(mclk), .rst(rst), .req(req), .delay_ms(delay_ms),
`ifdef DELAY_SCHED_CANCEL_EN
        .cancel(cancel),
`endif
        .ack(ack), .done(done), .busy(busy), .owner(owner)
    );

    delay_scheduler #(.NREQ(2), .MFREQ_KHZ(1)) dut_long (
        .mclk(mclk), .rst(rst2), .req(req2), .delay_ms(delay2),
`ifdef DELAY_SCHED_CANCEL_EN
        .cancel(cancel2),
`endif
        .ack(ack2), .done(done2), .busy(busy2), .owner(owner2)
    );

    always #5 mclk = ~mclk;

    function automatic void model_reset();
        exp_q.delete();
        m_ptr   = 0;
        m_ack   = 0;
        m_free  = 0;
        m_owner = 0;
    endfunction

    // Reference model: for cycle c, idle means c >= m_free; a grant gives ack at c+1, done at c+2+D*M.
    task automatic model_step(input int c);
        int   w;
        int   d;
        exp_t e;
        w = -1;
        d = 0;
`ifdef DELAY_SCHED_CANCEL_EN
        if (c >= m_ack && c < m_free && cancel[m_owner]) begin
            if (exp_q.size() > 0 && exp_q[$].is_done) exp_q.pop_back();
            m_free = c + 1;
        end else
`endif
        if (c >= m_free && req != 0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            d = int'(delay_ms[16*w +: 16]);
            e.is_done = 1'b0; e.idx = w; e.cyc = c + 1;
            exp_q.push_back(e);
            e.is_done = 1'b1; e.idx = w; e.cyc = c + 2 + d * M;
            exp_q.push_back(e);
            m_ack   = c + 1;
            m_free  = c + 2 + d * M;
            m_owner = w;
            m_ptr   = (w + 1) % N;
        end
    endtask

    // Model advance on every active edge; the cycle index counts edges.
    always @(posedge mclk) begin
        if (!rst) model_step(cyc);
        cyc <= cyc + 1;
    end

    // Monitor: checks reset values, busy every cycle, and pops the scoreboard on each ack/done pulse.
    always @(negedge mclk) begin
        exp_t e;
        int   exp_vec;
        int   act;
        if (rst) begin
            total++;
            if (ack != 0 || done != 0 || busy != 0 || owner != 0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: ack=%b done=%b busy=%b owner=%0d, required all zero",
                         ack, done, busy, owner);
            end
        end else begin
            total++;
            if (busy !== (cyc >= m_ack && cyc < m_free)) begin
                bad++;
                $display("[TB] FAIL busy@%0d: got %b expected %b", cyc, busy, (cyc >= m_ack && cyc < m_free));
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missed_%s: idx %0d due at cycle %0d never seen", e.is_done ? "done" : "ack", e.idx, e.cyc);
            end
            if (ack != 0 || done != 0) begin
                total++;
                if (ack != 0 && done != 0) begin
                    bad++;
                    $display("[TB] FAIL overlap@%0d: ack=%b done=%b both high", cyc, ack, done);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected@%0d: ack=%b done=%b, expected nothing", cyc, ack, done);
                end else begin
                    e = exp_q.pop_front();
                    exp_vec = 1 << e.idx;
                    act = (done != 0) ? int'(done) : int'(ack);
                    if (e.cyc != cyc || e.is_done != (done != 0) || act != exp_vec) begin
                        bad++;
                        $display("[TB] FAIL pulse@%0d: got %s=%b expected %s=%b at cycle %0d",
                                 cyc, (done != 0) ? "done" : "ack", act[N-1:0],
                                 e.is_done ? "done" : "ack", exp_vec[N-1:0], e.cyc);
                    end else if (!e.is_done) begin
                        total++;
                        if (int'(owner) != e.idx) begin
                            bad++;
                            $display("[TB] FAIL owner@%0d: got %0d expected %0d", cyc, owner, e.idx);
                        end
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Advance one cycle; requesters drop req in their ack cycle.
    task automatic step();
        @(posedge mclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) req[i] = 1'b0;
        end
    endtask

    task automatic wait_bit(input bit want_done, input int i, input int limit, output int n, output bit ok);
        logic [N-1:0] v;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            step();
            n++;
            v = want_done ? done : ack;
            if (v[i]) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_delay(input int i, input int d);
        delay_ms[16*i +: 16] = 16'(d);
    endtask

    // Randomized requesters: raise, occasionally withdraw, and change delays of idle requesters.
    task automatic apply_stimulus(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    set_delay(i, int'($urandom_range(0, 3)));
                    if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic main_sequence();
        int n;
        bit ok;
        int pulses;

        do_reset();
        step();

        // single request, delay 3
        set_delay(0, 3);
        req = 4'b0001;
        wait_bit(1'b0, 0, 10, n, ok);
        check_output("t1_ack_seen", int'(ok), 1);
        check_output("t1_ack_vec", int'(ack), 1);
        wait_bit(1'b1, 0, 50, n, ok);
        check_output("t1_done_seen", int'(ok), 1);
        check_output("t1_done_latency", n, 3 * M + 1);

        // all four with delay 0, round-robin order from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) set_delay(i, 0);
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_bit(1'b0, k, 10, n, ok);
            check_output($sformatf("t2_ack%0d_vec", k), ok ? int'(ack) : 0, 1 << k);
            if (k > 0) check_output($sformatf("t2_ack%0d_gap", k), n, 2);
        end
        repeat (4) step();

        // fairness: req0 re-raised right after its done loses to pending req2
        do_reset();
        set_delay(0, 2);
        set_delay(2, 0);
        req = 4'b0001;
        wait_bit(1'b0, 0, 10, n, ok);
        check_output("t3_first_ack", int'(ok), 1);
        req[2] = 1'b1;
        wait_bit(1'b1, 0, 50, n, ok);
        check_output("t3_done0_seen", int'(ok), 1);
        set_delay(0, 0);
        req[0] = 1'b1;
        wait_bit(1'b0, 2, 10, n, ok);
        check_output("t3_req2_first", ok ? int'(ack) : 0, 4);
        wait_bit(1'b0, 0, 10, n, ok);
        check_output("t3_req0_next", ok ? int'(ack) : 0, 1);
        repeat (4) step();

        // reset during a D=5 count discards it
        do_reset();
        set_delay(1, 5);
        req = 4'b0010;
        wait_bit(1'b0, 1, 10, n, ok);
        check_output("t4_ack1", int'(ok), 1);
        repeat (3) step();
        rst = 1'b1;
        model_reset();
        #1;
        check_output("t4_reset_now", int'({ack, done, busy, owner}), 0);
        step();
        step();
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (done != 0) pulses++;
        end
        check_output("t4_no_done", pulses, 0);
        set_delay(0, 3);
        set_delay(3, 3);
        req = 4'b1001;
        wait_bit(1'b0, 0, 10, n, ok);
        check_output("t4_ptr_reset", ok ? int'(ack) : 0, 1);
        wait_bit(1'b1, 0, 50, n, ok);
        check_output("t4_done_latency", ok ? n : -1, 3 * M + 1);
        wait_bit(1'b1, 3, 50, n, ok);
        check_output("t4_done3_seen", int'(ok), 1);

`ifdef DELAY_SCHED_CANCEL_EN
        // owner cancel aborts; a non-owner cancel is ignored
        do_reset();
        set_delay(1, 4);
        req = 4'b0010;
        wait_bit(1'b0, 1, 10, n, ok);
        check_output("t6_ack1", int'(ok), 1);
        step();
        cancel = 4'b0100;
        step();
        cancel = 4'b0000;
        check_output("t6_busy_after_foreign", int'(busy), 1);
        step();
        cancel = 4'b0010;
        step();
        cancel = 4'b0000;
        check_output("t6_busy_after_cancel", int'(busy), 0);
        pulses = 0;
        for (int t = 0; t < 15; t++) begin
            step();
            if (done != 0) pulses++;
        end
        check_output("t6_no_done", pulses, 0);
`endif

        // randomized traffic
        do_reset();
        apply_stimulus(500);
        req = '0;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            step();
            n++;
        end
        check_output("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic long_sequence();
        bit ok;
        int first_k;
        int busy_late;
        int done_vec;
        ok = 1'b0;
        first_k = -1;
        busy_late = 0;
        done_vec = 0;
        repeat (3) @(posedge mclk);
        #1;
        rst2 = 1'b0;
        delay2 = 32'h0000_FFFF;
        req2 = 2'b01;
        for (int t = 0; t < 5 && !ok; t++) begin
            @(posedge mclk);
            #1;
            if (ack2[0]) ok = 1'b1;
        end
        req2 = 2'b00;
        check_output("long_ack", int'(ok), 1);
        if (ok) begin
            for (int k = 1; k <= 65540 && first_k < 0; k++) begin
                @(posedge mclk);
                #1;
                if (k == 65535) busy_late = int'(busy2);
                if (done2 != 0) begin
                    first_k = k;
                    done_vec = int'(done2);
                end
            end
        end
        check_output("long_done_cycle", first_k, 65536);
        check_output("long_done_vec", done_vec, 1);
        check_output("long_busy_before_done", busy_late, 1);
    endtask

    initial begin
        fork
            main_sequence();
            long_sequence();
        join
        repeat (2) @(posedge mclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
